// File: rtl/stream_mux_rr.sv
// N-channel streaming multiplexer: fixed-select or round-robin arbitration into a
// single registered output beat with valid/ready handshakes on every port.
module stream_mux_rr #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mode,
    input  logic [SEL_W-1:0] i_sel,
    input  logic [N*W-1:0]   i_in_data,
    input  logic [N-1:0]     i_in_valid,
    output logic [N-1:0]     o_in_ready,
    output logic [W-1:0]     o_out_data,
    output logic [SEL_W-1:0] o_out_chan,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic [N-1:0]     w_grant;
    logic             w_found;
    int               w_idx;
    logic             w_xfer;
    logic [SEL_W-1:0] w_xfer_idx;
    logic [W-1:0]     w_xfer_data;

    assign w_load_en = !r_out_valid || i_out_ready;

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (i_mode) begin
            // Scan ptr, ptr+1, ... wrapping; first valid channel wins.
            for (int k = 0; k < N; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N) begin
                    w_idx = w_idx - N;
                end
                for (int i = 0; i < N; i++) begin
                    if (i == w_idx && !w_found && i_in_valid[i]) begin
                        w_grant[i] = 1'b1;
                        w_found    = 1'b1;
                    end
                end
            end
        end else begin
            // A sel value of N or more matches no channel and grants nothing.
            for (int i = 0; i < N; i++) begin
                if (i_sel == SEL_W'(i)) begin
                    w_grant[i] = i_in_valid[i];
                end
            end
        end
    end

    always_comb begin
        w_xfer_idx  = '0;
        w_xfer_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_xfer_idx  = SEL_W'(i);
                w_xfer_data = i_in_data[i*W +: W];
            end
        end
    end

    assign o_in_ready = rst_n ? (w_grant & {N{w_load_en}}) : '0;
    assign w_xfer     = |o_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_data  <= w_xfer_data;
                r_out_chan  <= w_xfer_idx;
                r_out_valid <= 1'b1;
                if (i_mode) begin
                    r_ptr <= (w_xfer_idx == SEL_W'(N - 1)) ? '0 : w_xfer_idx + 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_chan  = r_out_chan;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N=4, W=8): reset, fixed select, round-robin,
// idle-channel skip, backpressure, idle fixed select and mid-stream reset.
module tb_stream_mux_rr;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_chan;
    logic             out_valid;
    logic             out_ready;

    int total;
    int bad;

    stream_mux_rr #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mode     (mode),
        .i_sel      (sel),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .o_out_data (out_data),
        .o_out_chan (out_chan),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (out_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d exp=0", out_chan); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
        repeat (2) @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_fixed();
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b1111;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (out_data !== 8'h32) begin bad++; $display("FAIL fixed_data[%0d] got=%h exp=32", k, out_data); end
            total++; if (out_chan !== 2'd2) begin bad++; $display("FAIL fixed_chan[%0d] got=%0d exp=2", k, out_chan); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fixed_valid[%0d] got=%b exp=1", k, out_valid); end
            total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready[%0d] got=%b exp=0100", k, in_ready); end
        end
    endtask

    task automatic test_rr_rotation();
        logic [SEL_W-1:0] exp_chan [8];
        logic [W-1:0]     exp_data [8];
        exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        exp_data = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21, 8'h32, 8'h43};
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++; if (out_chan !== exp_chan[k]) begin bad++; $display("FAIL rr_chan[%0d] got=%0d exp=%0d", k, out_chan, exp_chan[k]); end
            total++; if (out_data !== exp_data[k]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_data, exp_data[k]); end
        end
    endtask

    task automatic test_skip_idle();
        logic [SEL_W-1:0] exp_chan [4];
        exp_chan = '{2'd1, 2'd3, 2'd1, 2'd3};
        in_valid = 4'b1010;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL skip_ready got=%b exp=0010", in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (out_chan !== exp_chan[k]) begin bad++; $display("FAIL skip_chan[%0d] got=%0d exp=%0d", k, out_chan, exp_chan[k]); end
        end
    endtask

    task automatic test_backpressure();
        // Output holds ch3 / 0x43 from the skip test; pointer is back at 0.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, in_ready); end
            total++; if (out_data !== 8'h43) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=43", k, out_data); end
            total++; if (out_chan !== 2'd3) begin bad++; $display("FAIL bp_chan[%0d] got=%0d exp=3", k, out_chan); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
        @(negedge clk);
        total++; if (out_chan !== 2'd0) begin bad++; $display("FAIL bp_drain_chan got=%0d exp=0", out_chan); end
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL bp_drain_data got=%h exp=10", out_data); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_drain_valid got=%b exp=1", out_valid); end
    endtask

    task automatic test_fixed_idle();
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b exp=0000", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL idle_pre_valid got=%b exp=1", out_valid); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid[%0d] got=%b exp=0", k, out_valid); end
            total++; if (out_data !== 8'h10) begin bad++; $display("FAIL idle_hold_data[%0d] got=%h exp=10", k, out_data); end
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready[%0d] got=%b exp=0000", k, in_ready); end
        end
    endtask

    task automatic test_mid_reset();
        // Round-robin pointer sits at 1 here; reset must return it to 0.
        sel      = 2'd0;
        in_data  = {8'h43, 8'h32, 8'h21, 8'h5A};
        in_valid = 4'b0001;
        @(negedge clk);
        total++; if (out_data !== 8'h5A) begin bad++; $display("FAIL mid_load_data got=%h exp=5a", out_data); end
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h exp=00", out_data); end
        total++; if (out_chan !== 2'd0) begin bad++; $display("FAIL mid_reset_chan got=%0d exp=0", out_chan); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_ready got=%b exp=0001", in_ready); end
        @(negedge clk);
        total++; if (out_chan !== 2'd0) begin bad++; $display("FAIL mid_first_chan got=%0d exp=0", out_chan); end
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL mid_first_data got=%h exp=10", out_data); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_skip_idle();
        test_backpressure();
        test_fixed_idle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
